// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for the instruction/data memory arbiter: state
// encodings, port-select constants and the wait-counter width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBusyI = 2'b01,
        StBusyD = 2'b10
    } arb_state_e;

    typedef enum logic {
        PortI = 1'b0,
        PortD = 1'b1
    } port_sel_e;

    localparam int unsigned WaitCntW = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one downstream memory port,
// with optional round-robin on contention and a downstream wait timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,

    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,

    output logic        bus_err
);

    localparam logic [WaitCntW-1:0] TimeoutCnt = WaitCntW'(TIMEOUT);

    arb_state_e          state_q, state_d;
    port_sel_e           last_q, last_d;
    logic [WaitCntW-1:0] cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                pick_d;
    logic                done;
    logic                timed_out;

    assign timed_out = (cnt_q >= TimeoutCnt);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        pick_d  = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // D wins when alone, always in fixed priority, or when I was served last.
                pick_d = d_valid && (!i_valid || !ROUND_ROBIN || (last_q == PortI));
                if (i_valid || d_valid) begin
                    cnt_d = '0;
                    if (pick_d) begin
                        state_d = StBusyD;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        wstrb_d = d_wstrb;
                    end else begin
                        state_d = StBusyI;
                        addr_d  = i_addr;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                end
            end
            StBusyI, StBusyD: begin
                if (m_ready || timed_out) begin
                    done    = 1'b1;
                    state_d = StIdle;
                    last_d  = (state_q == StBusyD) ? PortD : PortI;
                end else begin
                    cnt_d = cnt_q + WaitCntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are gated by reset so an in-flight transfer never completes during reset.
    assign m_valid = (state_q != StIdle) && !reset;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_wstrb = wstrb_q;

    assign i_ready = done && (state_q == StBusyI) && !reset;
    assign d_ready = done && (state_q == StBusyD) && !reset;
    assign bus_err = done && !m_ready && !reset;

    assign i_rdata = (i_ready && !m_ready) ? '0 : m_rdata;
    assign d_rdata = (d_ready && !m_ready) ? '0 : m_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= PortI;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model with a shadow memory.
module tb_mem_arbiter;

    localparam int unsigned TO = 8;
    localparam logic [31:0] FpKey = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        i_valid, i_ready, d_valid, d_ready, m_valid, m_ready, bus_err;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  d_wstrb, m_wstrb;

    logic        f_i_valid, f_i_ready, f_d_valid, f_d_ready, f_m_valid, f_m_ready, f_bus_err;
    logic [31:0] f_i_addr, f_i_rdata, f_d_addr, f_d_wdata, f_d_rdata, f_m_addr, f_m_wdata;
    logic [31:0] f_m_rdata;
    logic [3:0]  f_d_wstrb, f_m_wstrb;

    int checks = 0;
    int errors = 0;

    logic [31:0] shadow [256];
    bit mem_en    = 1'b1;
    bit rand_lat  = 1'b0;
    int fixed_lat = 0;

    mem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata), .bus_err(bus_err)
    );

    mem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .reset(reset),
        .i_valid(f_i_valid), .i_ready(f_i_ready), .i_addr(f_i_addr), .i_rdata(f_i_rdata),
        .d_valid(f_d_valid), .d_ready(f_d_ready), .d_addr(f_d_addr), .d_wdata(f_d_wdata),
        .d_wstrb(f_d_wstrb), .d_rdata(f_d_rdata),
        .m_valid(f_m_valid), .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb),
        .m_ready(f_m_ready), .m_rdata(f_m_rdata), .bus_err(f_bus_err)
    );

    function automatic logic [31:0] pat(input int w);
        if (w == 4) return 32'h0000_0013;
        return 32'hA500_0000 + 32'(w) * 32'h0001_0203;
    endfunction

    // Downstream memory: answers after a configurable number of waited cycles.
    logic [31:0] mem [256];
    bit mem_loaded = 1'b0;
    int wait_c = 0;
    int cur_lat = 0;
    always @(posedge clk) begin
        m_ready <= 1'b0;
        m_rdata <= 32'($urandom);
        if (reset) begin
            wait_c <= 0;
            if (!mem_loaded) begin
                for (int w = 0; w < 256; w++) mem[w] <= pat(w);
                mem_loaded <= 1'b1;
            end
        end else if (m_valid && !m_ready && mem_en) begin
            if (wait_c >= (rand_lat ? cur_lat : fixed_lat)) begin
                m_ready <= 1'b1;
                wait_c  <= 0;
                cur_lat <= int'($urandom_range(0, 3));
                m_rdata <= mem[m_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end else begin
                wait_c <= wait_c + 1;
            end
        end
    end

    // Single-cycle responder for the fixed-priority instance.
    always @(posedge clk) begin
        f_m_ready <= !reset && f_m_valid && !f_m_ready;
        f_m_rdata <= f_m_addr ^ FpKey;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        i_valid = 1'b1; d_valid = 1'b1; i_addr = 32'h8; d_addr = 32'hC;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({m_valid, i_ready, d_ready, bus_err, f_m_valid} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected 00000",
                         {m_valid, i_ready, d_ready, bus_err, f_m_valid});
            end
        end
        @(posedge clk);
        #1 reset = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: m_valid got %b expected 0", m_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        pulse_reset();
        i_valid = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c0: m_valid/i_ready got %b%b expected 00", m_valid, i_ready);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 32'h10 || m_wstrb !== 4'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_req: got v=%b a=%h s=%h w=%h expected v=1 a=10 s=0 w=0",
                     m_valid, m_addr, m_wstrb, m_wdata);
        end
        @(negedge clk);
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h13 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp: got ir=%b data=%h dr=%b expected ir=1 data=00000013 dr=0",
                     i_ready, i_rdata, d_ready);
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gap: m_valid/i_ready got %b%b expected 00", m_valid, i_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        bit got = 1'b0;
        pulse_reset();
        d_valid = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_BABE; d_wstrb = 4'hF;
        repeat (2) @(negedge clk);
        checks++;
        if (m_addr !== 32'h40 || m_wdata !== 32'hCAFE_BABE || m_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL write_fwd: got a=%h w=%h s=%h expected a=40 w=cafebabe s=f",
                     m_addr, m_wdata, m_wstrb);
        end
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_done: d/i_ready got %b%b expected 10", d_ready, i_ready);
        end
        shadow[16] = 32'hCAFE_BABE;
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(posedge clk);
        #1 d_valid = 1'b1; d_wstrb = 4'h0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (d_ready === 1'b1) begin
                got = 1'b1;
                checks++;
                if (d_rdata !== 32'hCAFE_BABE) begin
                    errors++;
                    $display("FAIL read_back: got %h expected cafebabe", d_rdata);
                end
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL read_back_timeout: got no d_ready expected d_ready within 10 cycles");
        end
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        string order = "";
        int n = 0;
        pulse_reset();
        i_valid = 1'b1; i_addr = 32'h100; d_valid = 1'b1; d_addr = 32'h200; d_wstrb = 4'h0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (d_ready === 1'b1) begin
                order = {order, "D"}; n++;
                checks++;
                if (d_rdata !== shadow[128]) begin
                    errors++;
                    $display("FAIL rr_d_data: got %h expected %h", d_rdata, shadow[128]);
                end
            end
            if (i_ready === 1'b1) begin
                order = {order, "I"}; n++;
                checks++;
                if (i_rdata !== shadow[64]) begin
                    errors++;
                    $display("FAIL rr_i_data: got %h expected %h", i_rdata, shadow[64]);
                end
            end
        end
        checks++;
        if (order != "DIDI") begin
            errors++;
            $display("FAIL rr_order: got %s expected DIDI", order);
        end
        @(posedge clk);
        #1 i_valid = 1'b0; d_valid = 1'b0;
    endtask

    task automatic test_fixed_priority();
        int nd = 0;
        bit got_i = 1'b0;
        bit early_i = 1'b0;
        pulse_reset();
        f_i_valid = 1'b1; f_i_addr = 32'h30; f_d_valid = 1'b1; f_d_addr = 32'h60;
        for (int c = 0; c < 40 && nd < 3; c++) begin
            @(negedge clk);
            if (f_i_ready === 1'b1) early_i = 1'b1;
            if (f_d_ready === 1'b1) begin
                nd++;
                checks++;
                if (f_d_rdata !== (32'h60 ^ FpKey)) begin
                    errors++;
                    $display("FAIL fp_d_data: got %h expected %h", f_d_rdata, 32'h60 ^ FpKey);
                end
            end
        end
        checks++;
        if (nd != 3 || early_i) begin
            errors++;
            $display("FAIL fp_d_wins: got d=%0d i_served=%b expected d=3 i_served=0", nd, early_i);
        end
        @(posedge clk);
        #1 f_d_valid = 1'b0;
        for (int c = 0; c < 10 && !got_i; c++) begin
            @(negedge clk);
            if (f_m_valid === 1'b1 && (f_m_wstrb !== 4'h0 || f_m_wdata !== 32'h0)) begin
                checks++; errors++;
                $display("FAIL fp_i_fields: got s=%h w=%h expected s=0 w=0", f_m_wstrb, f_m_wdata);
            end
            if (f_i_ready === 1'b1) begin
                got_i = 1'b1;
                checks++;
                if (f_i_rdata !== (32'h30 ^ FpKey) || f_d_ready !== 1'b0 || f_bus_err !== 1'b0) begin
                    errors++;
                    $display("FAIL fp_i_after_d: got data=%h dr=%b err=%b expected %h 0 0",
                             f_i_rdata, f_d_ready, f_bus_err, 32'h30 ^ FpKey);
                end
            end
        end
        if (!got_i) begin
            checks++; errors++;
            $display("FAIL fp_i_timeout: got no i_ready expected i_ready within 10 cycles");
        end
        @(posedge clk);
        #1 f_i_valid = 1'b0;
    endtask

    task automatic test_timeout();
        bit bad = 1'b0;
        pulse_reset();
        mem_en = 1'b0;
        d_valid = 1'b1; d_addr = 32'h20; d_wstrb = 4'h0;
        @(negedge clk);
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || d_ready !== 1'b0 || bus_err !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL timeout_wait: got early ready/err or dropped m_valid expected busy wait");
        end
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h0 || bus_err !== 1'b1 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got dr=%b data=%h err=%b ir=%b expected 1 0 1 0",
                     d_ready, d_rdata, bus_err, i_ready);
        end
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: m_valid/bus_err got %b%b expected 00", m_valid, bus_err);
        end
        mem_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout_race();
        int lat = -1;
        bit saw_err = 1'b0;
        pulse_reset();
        fixed_lat = int'(TO) - 1;
        d_valid = 1'b1; d_addr = 32'h44; d_wstrb = 4'h0;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (bus_err === 1'b1) saw_err = 1'b1;
            if (d_ready === 1'b1) begin
                lat = c;
                checks++;
                if (d_rdata !== shadow[17]) begin
                    errors++;
                    $display("FAIL race_data: got %h expected %h", d_rdata, shadow[17]);
                end
            end
        end
        checks++;
        if (lat != int'(TO) + 1 || saw_err) begin
            errors++;
            $display("FAIL race_normal: got lat=%0d err=%b expected lat=%0d err=0",
                     lat, saw_err, TO + 1);
        end
        fixed_lat = 0;
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        bit saw = 1'b0;
        pulse_reset();
        d_valid = 1'b1; d_addr = 32'h40; d_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_pre: m_valid got %b expected 1", m_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_during: m_valid/d_ready got %b%b expected 00", m_valid, d_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_after: m_valid/d_ready got %b%b expected 00", m_valid, d_ready);
        end
        repeat (5) begin
            @(negedge clk);
            if (d_ready !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL rst_busy_dropped: got d_ready pulse expected none");
        end
        @(posedge clk);
        #1 i_valid = 1'b1; i_addr = 32'h10;
        repeat (3) @(negedge clk);
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h13) begin
            errors++;
            $display("FAIL rst_busy_fetch: got ir=%b data=%h expected ir=1 data=00000013",
                     i_ready, i_rdata);
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit prev_i_v = 1'b0, prev_d_v = 1'b0, prev_m_v = 1'b0;
        bit last_d = 1'b0, cur_d = 1'b0, exp_d;
        bit i_done = 1'b0, d_done = 1'b0, saw_err = 1'b0, stall = 1'b0;
        int i_age = 0, d_age = 0, n_done = 0;
        logic [31:0] exp_data, got_data;
        pulse_reset();
        rand_lat = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (bus_err !== 1'b0) saw_err = 1'b1;
            if (m_valid === 1'b1 && !prev_m_v) begin
                exp_d = (prev_i_v && prev_d_v) ? !last_d : prev_d_v;
                cur_d = exp_d;
                checks++;
                if (!(prev_i_v || prev_d_v) || m_addr !== (exp_d ? d_addr : i_addr) ||
                    m_wstrb !== (exp_d ? d_wstrb : 4'h0)) begin
                    errors++;
                    $display("FAIL rand_grant: cyc %0d got a=%h s=%h expected port %s", cyc,
                             m_addr, m_wstrb, exp_d ? "D" : "I");
                end
            end
            if (i_ready === 1'b1 || d_ready === 1'b1) begin
                checks++;
                if (d_ready !== cur_d || i_ready !== !cur_d) begin
                    errors++;
                    $display("FAIL rand_port: cyc %0d got ir=%b dr=%b expected port %s", cyc,
                             i_ready, d_ready, cur_d ? "D" : "I");
                end
                if (cur_d && d_wstrb != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (d_wstrb[b]) shadow[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
                end else begin
                    exp_data = cur_d ? shadow[d_addr[9:2]] : shadow[i_addr[9:2]];
                    got_data = cur_d ? d_rdata : i_rdata;
                    checks++;
                    if (got_data !== exp_data) begin
                        errors++;
                        $display("FAIL rand_data: cyc %0d got %h expected %h", cyc, got_data,
                                 exp_data);
                    end
                end
                last_d = cur_d;
                n_done++;
                if (cur_d) d_done = 1'b1; else i_done = 1'b1;
            end
            prev_i_v = i_valid; prev_d_v = d_valid; prev_m_v = m_valid;
            i_age = i_valid ? i_age + 1 : 0;
            d_age = d_valid ? d_age + 1 : 0;
            if (i_age > 40 || d_age > 40) stall = 1'b1;
            @(posedge clk); #1;
            if (i_done) begin
                i_valid = 1'b0; i_done = 1'b0;
            end else if (!i_valid && $urandom_range(0, 2) == 0) begin
                i_valid = 1'b1;
                i_addr  = 32'($urandom_range(0, 15)) << 2;
            end
            if (d_done) begin
                d_valid = 1'b0; d_done = 1'b0;
            end else if (!d_valid && $urandom_range(0, 2) == 0) begin
                d_valid = 1'b1;
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_wdata = 32'($urandom);
                d_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
        end
        checks++;
        if (saw_err || stall || n_done < 100) begin
            errors++;
            $display("FAIL rand_health: got err=%b stall=%b done=%0d expected 0 0 >=100",
                     saw_err, stall, n_done);
        end
        i_valid = 1'b0; d_valid = 1'b0; rand_lat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        f_i_valid = 1'b0; f_i_addr = '0; f_d_valid = 1'b0; f_d_addr = '0;
        f_d_wdata = '0; f_d_wstrb = '0;
        for (int w = 0; w < 256; w++) shadow[w] = pat(w);
        test_reset();
        test_fetch();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_timeout_race();
        test_reset_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
